id_stage: RTL and testbench

Registered RV32I decode stage between fetch and execute; the parametrised successor to the combinational decoder. It decodes all RV32I base formats and generates immediates. It resolves operands from the register file or from `NFWD` forwarding sources, and detects load-use hazards with a stall. It hands one decoded instruction per beat to EX over a valid/ready handshake, and issues a one-cycle fetch redirect for JAL.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/id_fwd_mux.sv | 35 +++
 rtl/id_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_id_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, datapath default and immediate formats.
// The immediate helper builds the 32-bit form; callers sign-extend to their XLEN.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_SH = 3'd5
    } imm_fmt_e;

    // Only inst[31:7] carries immediate bits, so the opcode field is not passed in.
    function automatic logic [31:0] gen_imm(input logic [31:7] ib, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
            IMM_B:   imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
            IMM_U:   imm = {ib[31:12], 12'b0};
            IMM_J:   imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
            IMM_SH:  imm = {27'b0, ib[24:20]};
            default: imm = {{20{ib[31]}}, ib[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand resolver: priority mux over the forwarding sources, falling back to the
// register file. Source 0 is the youngest and wins; x0 always resolves to zero.
module id_fwd_mux
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NFWD = 2
) (
    input  logic [4:0]           rs_i,
    input  logic [XLEN-1:0]      rf_i,
    input  logic [NFWD-1:0]      fwd_we_i,
    input  logic [5*NFWD-1:0]    fwd_wa_i,
    input  logic [XLEN*NFWD-1:0] fwd_wd_i,
    input  logic [NFWD-1:0]      fwd_ld_i,
    output logic [XLEN-1:0]      data_o,
    output logic                 hit_ld_o
);

    always_comb begin
        data_o   = rf_i;
        hit_ld_o = 1'b0;
        // Walk oldest to youngest so the lowest matching index is the last writer.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we_i[i] && (fwd_wa_i[5*i +: 5] == rs_i)) begin
                data_o   = fwd_wd_i[XLEN*i +: XLEN];
                hit_ld_o = fwd_ld_i[i];
            end
        end
        if (rs_i == 5'd0) begin
            data_o   = '0;
            hit_ld_o = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: decodes, resolves operands, detects load-use
// hazards and hands one instruction per beat to EX; JAL redirects fetch directly.
module id_stage
    import rv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NFWD    = 2,
    parameter int NSQUASH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          if_inst,
    output logic [4:0]           rf_ra1,
    output logic [4:0]           rf_ra2,
    input  logic [XLEN-1:0]      rf_rd1,
    input  logic [XLEN-1:0]      rf_rd2,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [5*NFWD-1:0]    fwd_wa,
    input  logic [XLEN*NFWD-1:0] fwd_wd,
    input  logic [NFWD-1:0]      fwd_ld,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [6:0]           ex_op,
    output logic [2:0]           ex_f3,
    output logic                 ex_f7b5,
    output logic [XLEN-1:0]      ex_op1,
    output logic [XLEN-1:0]      ex_op2,
    output logic [XLEN-1:0]      ex_imm,
    output logic [XLEN-1:0]      ex_pc,
    output logic [4:0]           ex_wa,
    output logic                 ex_we,
    output logic                 ex_illegal,
    output logic                 redir_valid,
    output logic [XLEN-1:0]      redir_pc
);

    localparam int SQW = (NSQUASH < 1) ? 1 : $clog2(NSQUASH + 1);

    // Handshakes: a beat transfers on a cycle where valid && ready are both high;
    // valid never depends on ready, and the output register holds while valid && !ready.

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_en;
    logic            illegal;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_inst;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_ld;
    logic            rs2_ld;
    logic [XLEN-1:0] op1_sel;
    logic [XLEN-1:0] op2_sel;
    logic            stall;
    logic            out_free;
    logic            accept;

    logic            ex_valid_q,   ex_valid_d;
    logic [6:0]      ex_op_q,      ex_op_d;
    logic [2:0]      ex_f3_q,      ex_f3_d;
    logic            ex_f7b5_q,    ex_f7b5_d;
    logic [XLEN-1:0] ex_op1_q,     ex_op1_d;
    logic [XLEN-1:0] ex_op2_q,     ex_op2_d;
    logic [XLEN-1:0] ex_imm_q,     ex_imm_d;
    logic [XLEN-1:0] ex_pc_q,      ex_pc_d;
    logic [4:0]      ex_wa_q,      ex_wa_d;
    logic            ex_we_q,      ex_we_d;
    logic            ex_illegal_q, ex_illegal_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q,   redir_pc_d;
    logic [SQW-1:0]  squash_q,     squash_d;

    assign opc    = if_inst[6:0];
    assign f3     = if_inst[14:12];
    assign rd     = if_inst[11:7];
    assign rf_ra1 = if_inst[19:15];
    assign rf_ra2 = if_inst[24:20];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_en   = 1'b0;
        illegal = 1'b0;
        fmt     = IMM_I;
        case (opc)
            OP_LUI:   begin fmt = IMM_U; wr_en = 1'b1; end
            OP_AUIPC: begin fmt = IMM_U; wr_en = 1'b1; end
            OP_JAL:   begin fmt = IMM_J; wr_en = 1'b1; end
            OP_JALR:  begin fmt = IMM_I; wr_en = 1'b1; use_rs1 = 1'b1; end
            OP_BR:    begin fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LD:    begin fmt = IMM_I; wr_en = 1'b1; use_rs1 = 1'b1; end
            OP_ST:    begin fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IMM: begin
                fmt     = (f3[1:0] == 2'b01) ? IMM_SH : IMM_I;
                wr_en   = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_OP:    begin wr_en = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default:  illegal = 1'b1;
        endcase
    end

    assign imm     = XLEN'($signed(gen_imm(if_inst[31:7], fmt)));
    assign pc_inst = if_pc - XLEN'(4);

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
        .rs_i     (rf_ra1),
        .rf_i     (rf_rd1),
        .fwd_we_i (fwd_we),
        .fwd_wa_i (fwd_wa),
        .fwd_wd_i (fwd_wd),
        .fwd_ld_i (fwd_ld),
        .data_o   (rs1_val),
        .hit_ld_o (rs1_ld)
    );

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
        .rs_i     (rf_ra2),
        .rf_i     (rf_rd2),
        .fwd_we_i (fwd_we),
        .fwd_wa_i (fwd_wa),
        .fwd_wd_i (fwd_wd),
        .fwd_ld_i (fwd_ld),
        .data_o   (rs2_val),
        .hit_ld_o (rs2_ld)
    );

    always_comb begin
        op1_sel = rs1_val;
        if ((opc == OP_AUIPC) || (opc == OP_JAL)) begin
            op1_sel = pc_inst;
        end else if (opc == OP_LUI) begin
            op1_sel = '0;
        end
        op2_sel = imm;
        if ((opc == OP_OP) || (opc == OP_BR) || (opc == OP_ST)) begin
            op2_sel = rs2_val;
        end else if ((opc == OP_JAL) || (opc == OP_JALR)) begin
            op2_sel = if_pc;
        end
    end

    assign stall    = (use_rs1 && rs1_ld) || (use_rs2 && rs2_ld);
    assign out_free = !ex_valid_q || ex_ready;
    assign if_ready = !stall && out_free;
    assign accept   = if_valid && if_ready;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_op_d       = ex_op_q;
        ex_f3_d       = ex_f3_q;
        ex_f7b5_d     = ex_f7b5_q;
        ex_op1_d      = ex_op1_q;
        ex_op2_d      = ex_op2_q;
        ex_imm_d      = ex_imm_q;
        ex_pc_d       = ex_pc_q;
        ex_wa_d       = ex_wa_q;
        ex_we_d       = ex_we_q;
        ex_illegal_d  = ex_illegal_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        squash_d      = squash_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            squash_d   = '0;
        end else if (accept && (squash_q != '0)) begin
            // Wrong-path beat after a JAL: consume it but emit a bubble.
            squash_d   = squash_q - SQW'(1);
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d   = 1'b1;
            ex_op_d      = opc;
            ex_f3_d      = f3;
            ex_f7b5_d    = if_inst[30];
            ex_op1_d     = op1_sel;
            ex_op2_d     = op2_sel;
            ex_imm_d     = imm;
            ex_pc_d      = pc_inst;
            ex_wa_d      = rd;
            ex_we_d      = wr_en && (rd != 5'd0);
            ex_illegal_d = illegal;
            if (opc == OP_JAL) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = pc_inst + imm;
                squash_d      = SQW'(NSQUASH);
            end
        end else if (out_free) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_op_q       <= '0;
            ex_f3_q       <= '0;
            ex_f7b5_q     <= 1'b0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_imm_q      <= '0;
            ex_pc_q       <= '0;
            ex_wa_q       <= '0;
            ex_we_q       <= 1'b0;
            ex_illegal_q  <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            squash_q      <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_op_q       <= ex_op_d;
            ex_f3_q       <= ex_f3_d;
            ex_f7b5_q     <= ex_f7b5_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_imm_q      <= ex_imm_d;
            ex_pc_q       <= ex_pc_d;
            ex_wa_q       <= ex_wa_d;
            ex_we_q       <= ex_we_d;
            ex_illegal_q  <= ex_illegal_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            squash_q      <= squash_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_op       = ex_op_q;
    assign ex_f3       = ex_f3_q;
    assign ex_f7b5     = ex_f7b5_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_pc       = ex_pc_q;
    assign ex_wa       = ex_wa_q;
    assign ex_we       = ex_we_q;
    assign ex_illegal  = ex_illegal_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand-written multi-cycle sequences,
// then random traffic scored against a behavioural model of the stage.
module tb_id_stage;
    import rv_pkg::*;

    localparam int NFWD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_wa;
    logic [63:0] fwd_wd;
    logic [1:0]  fwd_ld;
    logic        ex_valid;
    logic        ex_ready;
    logic [6:0]  ex_op;
    logic [2:0]  ex_f3;
    logic        ex_f7b5;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_wa;
    logic        ex_we;
    logic        ex_illegal;
    logic        redir_valid;
    logic [31:0] redir_pc;

    int n_cmp = 0;
    int n_bad = 0;

    id_stage #(.XLEN(32), .NFWD(NFWD), .NSQUASH(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .fwd_we(fwd_we), .fwd_wa(fwd_wa), .fwd_wd(fwd_wd), .fwd_ld(fwd_ld),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_f3(ex_f3),
        .ex_f7b5(ex_f7b5), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_pc(ex_pc), .ex_wa(ex_wa), .ex_we(ex_we), .ex_illegal(ex_illegal),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        if_inst  = inst;
        if_pc    = pc;
        if_valid = 1'b1;
    endtask

    task automatic clear_fwd();
        fwd_we = '0;
        fwd_wa = '0;
        fwd_wd = '0;
        fwd_ld = '0;
    endtask

    // Behavioural reference model
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  wa;
        logic        we;
        logic        ill;
        logic        cimm;
        logic        cop2;
        logic        jal;
        logic [31:0] rpc;
    } exp_t;

    function automatic logic [31:0] m_resolve(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_we[i] && fwd_wa[5*i +: 5] == rs) return fwd_wd[32*i +: 32];
        return rf;
    endfunction

    function automatic bit m_pending_load(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_we[i] && fwd_wa[5*i +: 5] == rs) return fwd_ld[i];
        return 1'b0;
    endfunction

    function automatic bit m_stall(input logic [31:0] inst);
        logic [6:0] o;
        bit r1, r2;
        o  = inst[6:0];
        r1 = o inside {OP_OP, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JALR};
        r2 = o inside {OP_OP, OP_ST, OP_BR};
        return (r1 && m_pending_load(inst[19:15])) || (r2 && m_pending_load(inst[24:20]));
    endfunction

    function automatic exp_t m_decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] rd1, input logic [31:0] rd2);
        exp_t e;
        logic [6:0] o;
        bit legal;
        o     = inst[6:0];
        legal = o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP};
        e     = '0;
        e.op  = o;
        e.f3  = inst[14:12];
        e.f7  = inst[30];
        e.pc  = pc - 32'd4;
        e.wa  = inst[11:7];
        case (o)
            OP_LUI, OP_AUIPC: e.imm = {inst[31:12], 12'h000};
            OP_JAL:  e.imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            OP_BR:   e.imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            OP_ST:   e.imm = 32'($signed({inst[31:25], inst[11:7]}));
            OP_IMM:  e.imm = (inst[14:12] == 3'd1 || inst[14:12] == 3'd5)
                             ? 32'(inst[24:20]) : 32'($signed(inst[31:20]));
            default: e.imm = 32'($signed(inst[31:20]));
        endcase
        if (o == OP_AUIPC || o == OP_JAL) e.op1 = pc - 32'd4;
        else if (o == OP_LUI)             e.op1 = 32'd0;
        else                              e.op1 = m_resolve(inst[19:15], rd1);
        if (o inside {OP_OP, OP_BR, OP_ST})   e.op2 = m_resolve(inst[24:20], rd2);
        else if (o inside {OP_JAL, OP_JALR})  e.op2 = pc;
        else                                  e.op2 = e.imm;
        e.we   = (o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM, OP_LD})
                 && (inst[11:7] != 5'd0);
        e.ill  = !legal;
        e.cimm = legal && (o != OP_OP);
        e.cop2 = legal;
        e.jal  = (o == OP_JAL);
        e.rpc  = pc - 32'd4 + e.imm;
        return e;
    endfunction

    task automatic drive_random();
        logic [31:0] inst;
        logic [6:0]  o;
        case ($urandom_range(0, 9))
            0: o = OP_LUI;   1: o = OP_AUIPC; 2: o = OP_JAL; 3: o = OP_JALR;
            4: o = OP_BR;    5: o = OP_LD;    6: o = OP_ST;  7: o = OP_IMM;
            8: o = OP_OP;    default: o = 7'h7F;
        endcase
        inst         = $urandom();
        inst[6:0]    = o;
        inst[11:7]   = 5'($urandom_range(0, 3));
        inst[19:15]  = 5'($urandom_range(0, 3));
        inst[24:20]  = 5'($urandom_range(0, 3));
        if_inst      = inst;
        if_pc        = {$urandom_range(1, 16'hFFFF), 2'b00};
        if_valid     = ($urandom_range(0, 4) != 0);
        ex_ready     = ($urandom_range(0, 9) < 7);
        flush        = ($urandom_range(0, 19) == 0);
        rf_rd1       = $urandom();
        rf_rd2       = $urandom();
        for (int i = 0; i < NFWD; i++) begin
            fwd_we[i]         = $urandom_range(0, 1);
            fwd_wa[5*i +: 5]  = 5'($urandom_range(0, 3));
            fwd_wd[32*i +: 32] = $urandom();
            fwd_ld[i]         = fwd_we[i] && ($urandom_range(0, 6) == 0);
        end
    endtask

    // Directed vector table
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fwe;
        logic [9:0]  fwa;
        logic [63:0] fwd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  wa;
        logic        we;
        logic        ill;
        logic        cimm;
        logic        cop2;
    } vec_t;

    vec_t vt[13];

    // Scoreboard
    exp_t exp_q[$];

    initial begin
        exp_t e;
        bit   m_rdy;
        bit   next_redir;
        logic [31:0] next_rpc;
        int   squash;

        vt[0]  = '{32'h00500093, 32'h4,    2'b00, 10'h000, 64'h0,                   32'h0,    32'h5,        32'h5,        5'd1,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{32'h002081B3, 32'h8,    2'b11, 10'h021, {32'hAA, 32'hBB},        32'hBB,   32'h22,       32'h0,        5'd3,  1'b1, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{32'h123452B7, 32'hC,    2'b00, 10'h000, 64'h0,                   32'h0,    32'h12345000, 32'h12345000, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{32'hFFFFF317, 32'h1008, 2'b00, 10'h000, 64'h0,                   32'h1004, 32'hFFFFF000, 32'hFFFFF000, 5'd6,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{32'hFE20AE23, 32'h10,   2'b00, 10'h000, 64'h0,                   32'h11,   32'h22,       32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{32'hFE208CE3, 32'h14,   2'b00, 10'h000, 64'h0,                   32'h11,   32'h22,       32'hFFFFFFF8, 5'd25, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6]  = '{32'h00309213, 32'h18,   2'b00, 10'h000, 64'h0,                   32'h11,   32'h3,        32'h3,        5'd4,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{32'h41F0D213, 32'h1C,   2'b00, 10'h000, 64'h0,                   32'h11,   32'h1F,       32'h1F,       5'd4,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{32'hFFF12383, 32'h20,   2'b00, 10'h000, 64'h0,                   32'h11,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{32'h008280E7, 32'h200,  2'b00, 10'h000, 64'h0,                   32'h11,   32'h200,      32'h8,        5'd1,  1'b1, 1'b0, 1'b1, 1'b1};
        vt[10] = '{32'hFFFFFFFF, 32'h24,   2'b00, 10'h000, 64'h0,                   32'h11,   32'h0,        32'h0,        5'd31, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[11] = '{32'h00100013, 32'h28,   2'b00, 10'h000, 64'h0,                   32'h0,    32'h1,        32'h1,        5'd0,  1'b0, 1'b0, 1'b1, 1'b1};
        vt[12] = '{32'h000001B3, 32'h2C,   2'b01, 10'h000, {32'h0, 32'h99},         32'h0,    32'h0,        32'h0,        5'd3,  1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        if_pc = '0; if_inst = '0; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        clear_fwd();
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_ex_op1", ex_op1, 32'd0);
        chk("rst_ex_we", 32'(ex_we), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int v = 0; v < 13; v++) begin
            drive(vt[v].inst, vt[v].pc);
            fwd_we = vt[v].fwe; fwd_wa = vt[v].fwa; fwd_wd = vt[v].fwd; fwd_ld = '0;
            step();
            chk($sformatf("vec%0d_valid", v), 32'(ex_valid), 32'd1);
            chk($sformatf("vec%0d_op", v), 32'(ex_op), 32'(vt[v].inst[6:0]));
            chk($sformatf("vec%0d_f3", v), 32'(ex_f3), 32'(vt[v].inst[14:12]));
            chk($sformatf("vec%0d_f7b5", v), 32'(ex_f7b5), 32'(vt[v].inst[30]));
            chk($sformatf("vec%0d_op1", v), ex_op1, vt[v].op1);
            if (vt[v].cop2) chk($sformatf("vec%0d_op2", v), ex_op2, vt[v].op2);
            if (vt[v].cimm) chk($sformatf("vec%0d_imm", v), ex_imm, vt[v].imm);
            chk($sformatf("vec%0d_pc", v), ex_pc, vt[v].pc - 32'd4);
            chk($sformatf("vec%0d_wa", v), 32'(ex_wa), 32'(vt[v].wa));
            chk($sformatf("vec%0d_we", v), 32'(ex_we), 32'(vt[v].we));
            chk($sformatf("vec%0d_illegal", v), 32'(ex_illegal), 32'(vt[v].ill));
            chk($sformatf("vec%0d_ra1", v), 32'(rf_ra1), 32'(vt[v].inst[19:15]));
            chk($sformatf("vec%0d_ra2", v), 32'(rf_ra2), 32'(vt[v].inst[24:20]));
        end

        // Load-use stall: bubble while pending, then the instruction loads.
        drive(32'h002081B3, 32'h40);
        fwd_we = 2'b01; fwd_wa = 10'h001; fwd_wd = {32'h0, 32'h55}; fwd_ld = 2'b01;
        #1 chk("stall_if_ready", 32'(if_ready), 32'd0);
        step();
        chk("stall_bubble", 32'(ex_valid), 32'd0);
        step();
        chk("stall_bubble2", 32'(ex_valid), 32'd0);
        chk("stall_if_ready2", 32'(if_ready), 32'd0);
        fwd_ld = 2'b00;
        #1 chk("unstall_if_ready", 32'(if_ready), 32'd1);
        step();
        chk("unstall_valid", 32'(ex_valid), 32'd1);
        chk("unstall_op1", ex_op1, 32'h55);

        // Asynchronous reset in the middle of a held, stalled beat.
        ex_ready = 1'b0; fwd_ld = 2'b01;
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_op1", ex_op1, 32'd0);
        #3 rst_n = 1'b1;
        clear_fwd(); ex_ready = 1'b1; if_valid = 1'b0;
        step();

        // JAL: one-cycle redirect, next beat squashed, then normal flow.
        drive(32'h010000EF, 32'h104);
        step();
        chk("jal_valid", 32'(ex_valid), 32'd1);
        chk("jal_redir_valid", 32'(redir_valid), 32'd1);
        chk("jal_redir_pc", redir_pc, 32'h110);
        chk("jal_op2_link", ex_op2, 32'h104);
        chk("jal_op1", ex_op1, 32'h100);
        drive(32'h00500093, 32'h108);
        step();
        chk("jal_redir_pulse", 32'(redir_valid), 32'd0);
        chk("jal_squashed", 32'(ex_valid), 32'd0);
        drive(32'h00700113, 32'h10C);
        step();
        chk("post_squash_valid", 32'(ex_valid), 32'd1);
        chk("post_squash_op2", ex_op2, 32'd7);

        // Backpressure: hold three cycles, then release.
        ex_ready = 1'b0;
        drive(32'h00900213, 32'h110);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_valid", 32'(ex_valid), 32'd1);
            chk("bp_hold_op2", ex_op2, 32'd7);
            chk("bp_if_ready", 32'(if_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(if_ready), 32'd1);
        step();
        chk("bp_next_valid", 32'(ex_valid), 32'd1);
        chk("bp_next_op2", ex_op2, 32'd9);
        if_valid = 1'b0;
        step();
        chk("bp_no_dup", 32'(ex_valid), 32'd0);

        // Flush wins over a JAL load; no redirect, no squash left behind.
        drive(32'h010000EF, 32'h104);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_jal_valid", 32'(ex_valid), 32'd0);
        chk("flush_jal_redir", 32'(redir_valid), 32'd0);
        drive(32'h00700113, 32'h10C);
        step();
        chk("flush_no_squash", 32'(ex_valid), 32'd1);
        // Flush also clears a squash left pending by an earlier JAL.
        drive(32'h010000EF, 32'h104);
        step();
        chk("jal2_redir", 32'(redir_valid), 32'd1);
        if_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_kill_valid", 32'(ex_valid), 32'd0);
        drive(32'h00900213, 32'h108);
        step();
        chk("flush_clr_squash_valid", 32'(ex_valid), 32'd1);
        chk("flush_clr_squash_op2", ex_op2, 32'd9);
        if_valid = 1'b0;
        step();

        // Random traffic against the model.
        squash = 0;
        next_redir = 1'b0;
        next_rpc = '0;
        for (int c = 0; c < 600; c++) begin
            drive_random();
            #1;
            m_rdy = !m_stall(if_inst) && (exp_q.size() == 0 || ex_ready);
            chk("rnd_if_ready", 32'(if_ready), 32'(m_rdy));
            if (exp_q.size() != 0 && ex_ready) begin
                e = exp_q.pop_front();
                chk("rnd_op", 32'(ex_op), 32'(e.op));
                chk("rnd_f3", 32'(ex_f3), 32'(e.f3));
                chk("rnd_f7b5", 32'(ex_f7b5), 32'(e.f7));
                chk("rnd_op1", ex_op1, e.op1);
                if (e.cop2) chk("rnd_op2", ex_op2, e.op2);
                if (e.cimm) chk("rnd_imm", ex_imm, e.imm);
                chk("rnd_pc", ex_pc, e.pc);
                chk("rnd_wa", 32'(ex_wa), 32'(e.wa));
                chk("rnd_we", 32'(ex_we), 32'(e.we));
                chk("rnd_illegal", 32'(ex_illegal), 32'(e.ill));
            end
            next_redir = 1'b0;
            if (flush) begin
                exp_q.delete();
                squash = 0;
            end else if (if_valid && m_rdy) begin
                if (squash > 0) begin
                    squash--;
                end else begin
                    e = m_decode(if_inst, if_pc, rf_rd1, rf_rd2);
                    exp_q.push_back(e);
                    if (e.jal) begin
                        next_redir = 1'b1;
                        next_rpc   = e.rpc;
                        squash     = 1;
                    end
                end
            end
            step();
            chk("rnd_ex_valid", 32'(ex_valid), 32'(exp_q.size() != 0));
            chk("rnd_redir_valid", 32'(redir_valid), 32'(next_redir));
            if (next_redir) chk("rnd_redir_pc", redir_pc, next_rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
